// File: rtl/muldiv_pkg.sv
// Shared definitions for the E-stage multiply/divide controller:
// op encodings, controller states, default busy-window lengths and
// small op-classification helpers.
package muldiv_pkg;

  localparam int DATA_W          = 32;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Ops that open a busy window and produce a new HI/LO pair.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational multiply/divide datapath. Produces the full {HI,LO}
// result for MULT/MULTU/DIV/DIVU plus a divide-by-zero flag.
// Operands are widened to 33 bits (sign- or zero-extended) so signed and
// unsigned forms share one signed operator, and so the signed
// 0x80000000 / -1 case stays in range (quotient 2^31, low word 0x80000000).
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [63:0]       result,
  output logic              div_zero
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [32:0] b_safe;
  logic signed [63:0] a_wide;
  logic signed [63:0] b_wide;
  logic signed [63:0] prod;
  logic [31:0]        quot;
  logic [31:0]        rem;

  // Operand extension, product, truncating quotient and dividend-signed remainder.
  always_comb begin
    a_ext    = is_signed_op(op) ? {rs_val[31], rs_val} : {1'b0, rs_val};
    b_ext    = is_signed_op(op) ? {rt_val[31], rt_val} : {1'b0, rt_val};
    div_zero = (rt_val == '0);
    // A zero divisor is replaced so the divider never sees it; the
    // controller discards the result in that case anyway.
    b_safe   = div_zero ? 33'sd1 : b_ext;
    a_wide   = 64'(a_ext);
    b_wide   = 64'(b_ext);
    prod     = a_wide * b_wide;
    quot     = 32'(a_ext / b_safe);
    rem      = 32'(a_ext % b_safe);
    if (is_div(op)) begin
      result = {rem, quot};
    end else begin
      result = prod;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, runs arithmetic ops as a
// fixed-length busy window, serves MTHI/MTLO/MFHI/MFLO and raises stall when
// a mult/div-class instruction in D meets an operation in flight.
// Optional: define MULDIV_STALL_CNT_EN to add the saturating stall_cycles
// counter output.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              d_is_md,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] md_rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
`ifdef MULDIV_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DATA_W-1:0]  hi_d, lo_d;
  logic [DATA_W-1:0]  pend_hi, pend_lo, pend_hi_d, pend_lo_d;
  logic [63:0]        arith_result;
  logic               div_zero;
  logic               arith_start;

  muldiv_arith u_arith (
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  // Next-state, counter, pending-result and HI/LO update logic plus busy.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hi_d        = hi;
    lo_d        = lo;
    pend_hi_d   = pend_hi;
    pend_lo_d   = pend_lo;
    arith_start = start && is_arith(op);
    busy        = arith_start || (state == BUSY);
    unique case (state)
      IDLE: begin
        if (start) begin
          if (is_arith(op)) begin
            // Divide by zero keeps the committed pair so commit is a no-op.
            if (is_div(op) && div_zero) begin
              pend_hi_d = hi;
              pend_lo_d = lo;
            end else begin
              pend_hi_d = arith_result[63:32];
              pend_lo_d = arith_result[31:0];
            end
            cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = BUSY;
          end else if (op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      BUSY: begin
        // Any start seen here is ignored; the stall keeps it from happening.
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_d    = pend_hi;
          lo_d    = pend_lo;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and HI/LO/pending registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
    end
  end

  assign stall    = d_is_md && busy;
  assign md_rdata = (op == MD_MFHI) ? hi : lo;

`ifdef MULDIV_STALL_CNT_EN
  // Saturating count of edges on which the pipeline was stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the stimulus process drives one cycle at
// a time, predicts busy/stall/md_rdata/HI/LO from an arithmetic model and
// queues the prediction; a monitor pops and compares each cycle and checks
// every completed arithmetic op (result and busy-window length).
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] md_rdata, hi, lo;
`ifdef MULDIV_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] scnt;
  } cyc_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          aborted;
  } commit_t;

  cyc_t    cyc_q[$];
  commit_t commit_q[$];

  logic [31:0] m_hi, m_lo, m_phi, m_plo, m_scnt;
  int          m_left;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall    (stall),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo)
`ifdef MULDIV_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_arith(input logic [2:0] o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  // Reference result straight from the arithmetic definition using 64-bit math.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ch,
                                             input logic [31:0] cl);
    longint      sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV:   return (b == 32'd0) ? {ch, cl} : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  return (b == 32'd0) ? {ch, cl} : {32'(ua % ub), 32'(ua / ub)};
      default:  return {ch, cl};
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle, queue its prediction, advance the model across the edge.
  task automatic cycle(input logic rst, input logic st, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic dmd);
    cyc_t    e;
    commit_t c;
    bit      arith;
    reset   = rst;
    start   = st;
    op      = o;
    rs_val  = a;
    rt_val  = b;
    d_is_md = dmd;
    arith   = st && op_arith(o);
    e.busy  = arith || (m_left > 0);
    e.stall = dmd && e.busy;
    e.rdata = (o == MD_MFHI) ? m_hi : m_lo;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.scnt  = m_scnt;
    cyc_q.push_back(e);
    if (rst) m_scnt = 32'd0;
    else if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (rst) begin
      if (m_left > 0 && commit_q.size() > 0) commit_q[commit_q.size() - 1].aborted = 1'b1;
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      if (arith) begin
        {m_phi, m_plo} = ref_result(o, a, b, m_hi, m_lo);
        m_left    = (o == MD_DIV || o == MD_DIVU) ? N_DIV : N_MULT;
        c.hi      = m_phi;
        c.lo      = m_plo;
        c.lat     = m_left;
        c.aborted = 1'b0;
        commit_q.push_back(c);
      end else if (o == MD_MTHI) begin
        m_hi = a;
      end else if (o == MD_MTLO) begin
        m_lo = a;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic dmd);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, MD_MFLO, 32'd0, 32'd0, dmd);
  endtask

  // Monitor: per-cycle comparison and detection of each completed busy window.
  initial begin : monitor
    cyc_t    e;
    commit_t c;
    bit      in_op;
    bit      arith_now;
    int      lat;
    in_op = 1'b0;
    lat   = 0;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("stall", 32'(stall), 32'(e.stall));
        chk("md_rdata", md_rdata, e.rdata);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
`ifdef MULDIV_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, e.scnt);
`endif
        arith_now = start && op_arith(op);
        if (in_op && (!busy || arith_now)) begin
          if (commit_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit_q: busy window ended with no expected op queued at %0t", $time);
          end else begin
            c = commit_q.pop_front();
            if (!c.aborted) begin
              chk("commit_hi", hi, c.hi);
              chk("commit_lo", lo, c.lo);
              chk("busy_len", 32'(lat), 32'(c.lat));
            end
          end
          in_op = 1'b0;
        end else if (in_op) begin
          lat++;
        end
        if (arith_now && busy && !in_op) begin
          in_op = 1'b1;
          lat   = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; start = 1'b0; op = MD_MFLO; rs_val = '0; rt_val = '0; d_is_md = 1'b0;
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_scnt = '0; m_left = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state: idle, md instruction in D must not stall.
    cycle(1'b0, 1'b0, MD_MFLO, 32'd0, 32'd0, 1'b1);

    // MULT -3 * 5 with MFLO waiting in D during the busy window.
    cycle(1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle(N_MULT, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    cycle(1'b0, 1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
`ifdef MULDIV_STALL_CNT_EN
    chk("stall_cnt_seq", stall_cycles, 32'd5);
`endif

    // DIVU 7/2 and DIV -7/2 with a non-md instruction in D.
    cycle(1'b0, 1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0);
    idle(N_DIV, 1'b0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    cycle(1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(N_DIV, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // MTHI/MTLO then divide by zero keeps HI/LO.
    cycle(1'b0, 1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, MD_MTLO, 32'h0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, MD_DIV, 32'h0000_0055, 32'd0, 1'b1);
    idle(N_DIV, 1'b0);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'h0);

    // Signed overflow case.
    cycle(1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(N_DIV, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // MTHI arriving while busy is ignored.
    cycle(1'b0, 1'b1, MD_MULTU, 32'd6, 32'd7, 1'b0);
    cycle(1'b0, 1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    idle(N_MULT - 1, 1'b0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);

    // Reset in the third cycle of a DIV, then MULTU 0xFFFFFFFF * 2.
    cycle(1'b0, 1'b1, MD_DIVU, 32'd100, 32'd3, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    cycle(1'b0, 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(N_MULT, 1'b0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // Randomized legal flow: new ops only when the model says not busy.
    for (int k = 0; k < 400; k++) begin
      logic dmd;
      dmd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0)
        cycle(1'b1, 1'b0, MD_MFLO, 32'd0, 32'd0, dmd);
      else if (m_left > 0)
        cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), dmd);
      else if ($urandom_range(0, 3) != 0)
        cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), dmd);
      else
        cycle(1'b0, 1'b0, 3'($urandom_range(6, 7)), 32'd0, 32'd0, dmd);
    end

    idle(N_DIV + 2, 1'b0);
    chk("commit_drain", 32'(commit_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
